alu_arbiter: RTL and testbench

Shares the single combinational integer ALU between up to NREQ requesters (e.g. the execute stage and the address/branch-compare path) using valid/ready handshakes. Accepts one request at a time, registers its opcode and operands into the ALU, captures the result, and returns it to the owning requester with backpressure. Sits between the requesting pipeline stages and the `Alu` instance; it owns the ALU's `operation`, `op1` and `op2` inputs.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_arb_pick.sv | 55 +++++
 rtl/alu_arbiter.sv | 166 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU arbiter: opcode encoding, FSM states, default widths.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned OPW_DEFAULT  = 4;
    localparam int unsigned NREQ_DEFAULT = 2;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } arb_state_e;

    // Index width for n requesters; never zero so single-bit indices stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational grant picker: round-robin from last+1 when ALU_RR_ARB_EN is defined,
// otherwise fixed priority with the lowest index winning.
module alu_arb_pick
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] gnt_idx_o,
    output logic            gnt_any_o
);

`ifdef ALU_RR_ARB_EN
    logic [IDXW-1:0] cand_idx;

    always_comb begin
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        cand_idx  = last_i;
        // Walk the ring starting just after the previous winner.
        for (int k = 0; k < int'(NREQ); k++) begin
            cand_idx = (cand_idx == IDXW'(NREQ - 1)) ? '0 : cand_idx + 1'b1;
            if (!gnt_any_o && req_i[cand_idx]) begin
                gnt_any_o = 1'b1;
                gnt_idx_o = cand_idx;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last_i;

    always_comb begin
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!gnt_any_o && req_i[i]) begin
                gnt_any_o = 1'b1;
                gnt_idx_o = IDXW'(i);
            end
        end
    end
`endif

    always_comb begin
        gnt_o = '0;
        if (gnt_any_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ valid/ready requesters, one transaction at a time.
// Define ALU_RR_ARB_EN for round-robin arbitration; fixed priority otherwise.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned OPW  = OPW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OPW-1:0]  req_op,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]      rsp_data,
    output logic [OPW-1:0]       alu_operation,
    output logic [XLEN-1:0]      alu_op1,
    output logic [XLEN-1:0]      alu_op2,
    input  logic [XLEN-1:0]      alu_result
);

    localparam int unsigned IDXW = idx_width(NREQ);

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] own_q, own_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [NREQ-1:0] gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_any;
    logic [IDXW-1:0] last_sel;
    logic            arb_open;
    logic            accept;
    logic [OPW-1:0]  sel_op;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;

`ifdef ALU_RR_ARB_EN
    logic [IDXW-1:0] last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = gnt_idx;
        end
    end

    // Resetting to the top index makes requester 0 the first winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IDXW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

    assign last_sel = last_q;
`else
    assign last_sel = IDXW'(NREQ - 1);
`endif

    alu_arb_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i     (req_valid),
        .last_i    (last_sel),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_idx == IDXW'(i)) begin
                sel_op = req_op[i*OPW +: OPW];
                sel_a  = req_a[i*XLEN +: XLEN];
                sel_b  = req_b[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        arb_open = 1'b0;

        unique case (state_q)
            StIdle: arb_open = 1'b1;
            StExec: begin
                result_d = alu_result;
                state_d  = StResp;
            end
            StResp: begin
                // Consuming the result reopens arbitration in the same cycle.
                if (rsp_ready[own_q]) begin
                    arb_open = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        accept = arb_open & gnt_any;
        if (accept) begin
            own_d   = gnt_idx;
            op_d    = sel_op;
            a_d     = sel_a;
            b_d     = sel_b;
            state_d = StExec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            own_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    // req_ready is combinational from req_valid, so it is masked while reset is held.
    always_comb begin
        req_ready = '0;
        if (accept && !rst) begin
            req_ready = gnt;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == StResp) begin
            rsp_valid[own_q] = 1'b1;
        end
    end

    assign rsp_data      = result_q;
    assign alu_operation = op_q;
    assign alu_op1       = a_q;
    assign alu_op2       = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, scoreboard of grants vs responses.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  alu_operation;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_result;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } sb_t;

    sb_t sb_q[$];
    int  grant_log[$];
    sb_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(
        .NREQ (2),
        .XLEN (32),
        .OPW  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .alu_operation (alu_operation),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_result    (alu_result)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return {31'd0, $signed(a) < $signed(b)};
            4'd4:    return {31'd0, a < b};
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return $signed(a) >>> b[4:0];
            4'd8:    return a | b;
            4'd9:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_operation, alu_op1, alu_op2);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: push on request handshake, pop on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_e.idx  = i;
                    mon_e.data = alu_ref(req_op[i*4 +: 4], req_a[i*32 +: 32], req_b[i*32 +: 32]);
                    sb_q.push_back(mon_e);
                    grant_log.push_back(i);
                end
            end
            if (rsp_valid != 2'b00) begin
                check_eq("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
                if (sb_q.size() == 0) begin
                    check_eq("rsp_spurious", rsp_valid, 2'b00);
                end else if ((rsp_valid & rsp_ready) != 2'b00) begin
                    mon_e = sb_q.pop_front();
                    check_eq("rsp_idx", rsp_valid[1] ? 1 : 0, mon_e.idx);
                    check_eq("rsp_data", rsp_data, mon_e.data);
                end
            end
        end
    end

    always @(posedge rst) sb_q.delete();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_valid[i]       = 1'b1;
        req_op[i*4 +: 4]   = op;
        req_a[i*32 +: 32]  = a;
        req_b[i*32 +: 32]  = b;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 2'b00);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 2'b00);
        check_eq({tag, "_rsp_data"}, rsp_data, 32'd0);
        check_eq({tag, "_alu_operation"}, alu_operation, 4'd0);
        check_eq({tag, "_alu_op1"}, alu_op1, 32'd0);
        check_eq({tag, "_alu_op2"}, alu_op2, 32'd0);
    endtask

    initial begin
        logic [1:0] acc;
        int         exp_gnt;

        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset: every output quiet even with requests pending.
        #2;
        check_all_zero("reset");
        step();
        step();
        rst       = 1'b0;
        req_valid = 2'b00;

        // Single request, ADD 5+7.
        set_req(0, AluAdd, 32'd5, 32'd7);
        at_neg();
        check_eq("single_req_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        at_neg();
        check_eq("single_exec_no_rsp", rsp_valid, 2'b00);
        check_eq("single_alu_op", alu_operation, AluAdd);
        check_eq("single_alu_op1", alu_op1, 32'd5);
        check_eq("single_alu_op2", alu_op2, 32'd7);
        step();
        at_neg();
        check_eq("single_rsp_valid", rsp_valid, 2'b01);
        check_eq("single_rsp_data", rsp_data, 32'd12);
        step();
        rsp_ready = 2'b01;
        at_neg();
        step();
        rsp_ready = 2'b00;
        at_neg();
        check_eq("single_rsp_cleared", rsp_valid, 2'b00);

        // Backpressure on requester 1; non-owner rsp_ready must be ignored.
        step();
        set_req(1, AluSub, 32'd3, 32'd5);
        at_neg();
        check_eq("bp_req_ready", req_ready, 2'b10);
        step();
        req_valid[1] = 1'b0;
        set_req(0, AluAdd, 32'd1, 32'd2);
        rsp_ready = 2'b01;
        step();
        for (int k = 0; k < 4; k++) begin
            at_neg();
            check_eq("bp_rsp_valid", rsp_valid, 2'b10);
            check_eq("bp_rsp_data", rsp_data, 32'hFFFF_FFFE);
            check_eq("bp_req_ready", req_ready, 2'b00);
            step();
        end
        rsp_ready = 2'b10;
        at_neg();
        check_eq("bp_release_accept", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        at_neg();
        check_eq("bp_single_rsp", rsp_valid, 2'b00);
        step();
        at_neg();
        check_eq("bp_next_rsp", rsp_valid, 2'b01);
        step();
        rsp_ready = 2'b00;

        // Back-to-back: new request accepted in the consuming cycle.
        set_req(0, AluAdd, 32'd1, 32'd1);
        rsp_ready = 2'b11;
        at_neg();
        check_eq("b2b_first_ready", req_ready, 2'b01);
        step();
        req_valid[0] = 1'b0;
        set_req(1, AluSlt, 32'hFFFF_FFFF, 32'd1);
        at_neg();
        check_eq("b2b_exec_ready", req_ready, 2'b00);
        step();
        at_neg();
        check_eq("b2b_rsp0", rsp_valid, 2'b01);
        t0 = cyc;
        check_eq("b2b_same_cycle_accept", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        at_neg();
        check_eq("b2b_gap", rsp_valid, 2'b00);
        step();
        at_neg();
        check_eq("b2b_rsp1", rsp_valid, 2'b10);
        check_eq("b2b_rsp1_data", rsp_data, 32'd1);
        check_eq("b2b_spacing", cyc - t0, 2);
        step();
        rsp_ready = 2'b00;

        // Contention from a fresh reset.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        grant_log.delete();
        set_req(0, AluAdd, 32'd10, 32'd20);
        set_req(1, AluXor, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        rsp_ready = 2'b11;
        for (int k = 0; k < 8; k++) step();
        req_valid = 2'b00;
        step();
        step();
        check_eq("cont_grant_count", grant_log.size(), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
`ifdef ALU_RR_ARB_EN
            exp_gnt = k % 2;
`else
            exp_gnt = 0;
`endif
            check_eq($sformatf("cont_grant%0d", k), grant_log[k], exp_gnt);
        end
        rsp_ready = 2'b00;

        // Reset asserted during EXEC discards the transaction immediately.
        set_req(0, AluSub, 32'd9, 32'd4);
        at_neg();
        step();
        req_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        step();
        step();
        rst       = 1'b0;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            check_eq("midrst_no_rsp", rsp_valid, 2'b00);
            step();
        end
        set_req(1, AluOr, 32'h0000_000F, 32'h0000_00F0);
        at_neg();
        check_eq("midrst_new_grant", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        at_neg();
        step();
        at_neg();
        check_eq("midrst_new_rsp", rsp_valid, 2'b10);
        check_eq("midrst_new_data", rsp_data, 32'h0000_00FF);
        step();

        // Random traffic, operands held stable until accepted; includes undefined opcodes.
        req_valid = 2'b00;
        for (int c = 0; c < 80; c++) begin
            at_neg();
            acc = req_valid & req_ready;
            step();
            for (int i = 0; i < 2; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        set_req(i, 4'($urandom_range(0, 11)), $urandom, $urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = 2'($urandom_range(0, 3));
        end
        at_neg();
        step();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int k = 0; k < 6; k++) step();
        check_eq("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
